prog_countdown_7: RTL and testbench
===================================

# prog_countdown_7

Programmable 7-bit countdown timer, the down-counting counterpart to the programmable up-counter wrapper in the lab datapath. Loads a start value, clamped to 0–99 decimal, and decrements it under a run/pause control. It pulses `done` when it reaches zero and holds there until reloaded. It feeds the same two-digit display path and control logic that consume up-counter results.

## Interface
- `PRESCALE`, default 1: clock cycles per decrement, legal range 1–255.
- `MAX_VAL`, default 99: clamp ceiling for loaded values.
- `CLK`  input  1: sole clock, rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `start_count`  input  7: value to load, sampled only when `load`=1.
- `load`  input  1: synchronous load strobe; highest-priority command after `reset`.
- `run`  input  1: level; 1 = count, 0 = pause.
- `count_out`  output  7: current count, registered.
- `busy`  output  1: high while in COUNT.
- `done`  output  1: single-cycle pulse on reaching zero.
- `bcd_tens`, `bcd_ones`  output  4 each: BCD digits of `count_out`; present only with `PROG_COUNTDOWN_BCD_EN`.

## Operation
- States:
  - IDLE: after reset, nothing loaded.
  - HOLD: loaded and paused.
  - COUNT: decrementing.
  - DONE: at zero, waiting for reload.
- `load`=1, any state:
  - `count_out` ← min(`start_count`, `MAX_VAL`).
  - Prescaler ← 0.
  - Next state is HOLD, even if `run`=1.
- HOLD, `run`=1, `count_out`≠0: go to COUNT.
- HOLD, `run`=1, `count_out`=0: go to DONE and pulse `done`. No decrement happens.
- COUNT, `run`=0: go to HOLD. Prescaler and count freeze; counting resumes from the frozen values.
- COUNT, prescaler reaches `PRESCALE`-1:
  - Prescaler ← 0.
  - `count_out` ← `count_out`-1.
  - If the new value is 0: state → DONE, `done`=1 for that cycle only.
- DONE: `count_out` holds 0; `run` is ignored; only `load` leaves.
- IDLE: `run` is ignored; only `load` leaves.
- No wrap-around. Decrement below 0 is impossible by construction.
- Arithmetic: 7-bit unsigned. The clamp compares the full 7-bit input, so 100–127 load as 99.

## Timing
- Reset values: state IDLE, `count_out`=0, `busy`=0, `done`=0, prescaler 0, BCD outputs 0.
- `load` sampled at edge k: loaded value is visible on `count_out` after edge k.
- HOLD→COUNT transition at edge e: first decrement at edge e+`PRESCALE`.
- Full countdown from N>0 with `run` held high: `done` is asserted after edge e+N·`PRESCALE`, the same edge on which `count_out` becomes 0. `done` deasserts after the next edge.
- `busy` is registered and equals (state==COUNT). It deasserts on the same edge that `done` asserts.
- `load` and `run` both high at one edge: load wins. COUNT is entered one edge later if `run` is still high.
- `load` on the same edge a decrement would reach 0: load wins and no `done` pulse occurs.
- `reset` mid-count: all outputs return to reset values immediately, without waiting for a clock edge. Counting resumes only after a new `load`.

## Configuration
- `PROG_COUNTDOWN_BCD_EN` defined:
  - `bcd_tens` and `bcd_ones` ports exist.
  - Both are registered and update on the same edge as `count_out`; for example, 47 gives tens=4, ones=7.
  - Values are always within 0–9, since `count_out` ≤ 99.
- `PROG_COUNTDOWN_BCD_EN` undefined: both ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package `prog_count_pkg`:
  - State encoding type (IDLE, HOLD, COUNT, DONE).
  - `COUNT_W`=7.
  - `DEFAULT_MAX`=99.
- Sub-module `tick_prescaler`:
  - Inputs: `CLK`, `reset`, `clr`, `en`.
  - Output: `tick`, high for one cycle every `PRESCALE` enabled cycles.
  - Instantiated once. `clr` = `load`; `en` = (state==COUNT).
- Top level contains the FSM, the clamp, the down-counter and the optional BCD register.

## Test plan
- Reset asserted mid-cycle, asynchronously → `count_out`=0, `busy`=0, `done`=0 immediately; `load` remains required to restart.
- `PRESCALE`=1: load 5, then `run`=1 → `count_out` sequence 5,4,3,2,1,0 on consecutive edges; `done` high exactly one cycle, coincident with 0; state DONE.
- Load 120 → `count_out`=99. Load 0 with `run`=1 → one edge in HOLD, then `done` pulse; `count_out` never leaves 0.
- `PRESCALE`=3: load 4 with `run` high; drop `run` after the first decrement for 5 cycles, then restore → `count_out` holds 3 while paused; total `done` latency from the COUNT entry edge = 12 counting cycles plus the pause cycles plus one HOLD→COUNT re-entry edge.
- Load and `run` both asserted on the same edge during COUNT at value 1 → new value loaded, no `done` pulse, state HOLD.
- With `PROG_COUNTDOWN_BCD_EN`: load 47 → `bcd_tens`=4, `bcd_ones`=7; after 8 decrements → 3 and 9.

Source files
------------

// File: rtl/prog_countdown_7_pkg.sv
// Shared types and helpers for the programmable countdown timer.
// Optional BCD outputs are enabled with PROG_COUNTDOWN_BCD_EN.
package prog_count_pkg;

    localparam int COUNT_W     = 7;
    localparam int DEFAULT_MAX = 99;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Full 7-bit compare, so 100..127 saturate at the ceiling.
    function automatic logic [COUNT_W-1:0] clamp_load(input logic [COUNT_W-1:0] v,
                                                      input int max_val);
        if (int'(v) > max_val)
            return COUNT_W'(max_val);
        return v;
    endfunction

    function automatic logic [7:0] to_bcd(input logic [COUNT_W-1:0] v);
        int tens;
        int ones;
        tens = int'(v) / 10;
        ones = int'(v) - tens * 10;
        return {4'(tens), 4'(ones)};
    endfunction

endpackage

// File: rtl/prog_countdown_7_tick_prescaler.sv
// Divides enabled clock cycles down to one tick every PRESCALE enabled cycles.
// clr returns the divider to zero and overrides en.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic CLK,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Combinational tick lets the owner act on the same edge that wraps the divider.
    assign tick = en && (cnt_q == 8'(PRESCALE - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = 8'd0;
        else if (en)
            cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset)
            cnt_q <= 8'd0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/prog_countdown_7.sv
// Programmable 7-bit countdown timer: clamped load, run/pause, one-cycle done pulse.
// Define PROG_COUNTDOWN_BCD_EN to add registered bcd_tens/bcd_ones outputs.
module prog_countdown_7
    import prog_count_pkg::*;
#(
    parameter int PRESCALE = 1,
    parameter int MAX_VAL  = DEFAULT_MAX
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic [COUNT_W-1:0] start_count,
    input  logic               load,
    input  logic               run,
    output logic [COUNT_W-1:0] count_out,
    output logic               busy,
    output logic               done,
`ifdef PROG_COUNTDOWN_BCD_EN
    output logic [3:0]         bcd_tens,
    output logic [3:0]         bcd_ones,
`endif
    output state_e             state_dbg_o
);

    // Handshake: none; load is a one-cycle strobe taking priority over run,
    // run is a level sampled every edge, done is a one-cycle registered pulse.

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               busy_q;
    logic               done_q, done_d;
    logic               tick;
    logic               pre_en;

    // Gated by run so the divider freezes on the very edge that pauses.
    assign pre_en = (state_q == ST_COUNT) && run;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .CLK  (CLK),
        .reset(reset),
        .clr  (load),
        .en   (pre_en),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = ST_HOLD;
            count_d = clamp_load(start_count, MAX_VAL);
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_HOLD: begin
                    if (run) begin
                        if (count_q != '0) begin
                            state_d = ST_COUNT;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_COUNT: begin
                    if (!run) begin
                        state_d = ST_HOLD;
                    end else if (tick) begin
                        count_d = count_q - COUNT_W'(1);
                        if (count_q == COUNT_W'(1)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= (state_d == ST_COUNT);
            done_q  <= done_d;
        end
    end

    assign count_out   = count_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign state_dbg_o = state_q;

`ifdef PROG_COUNTDOWN_BCD_EN
    logic [7:0] bcd_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset)
            bcd_q <= 8'd0;
        else
            bcd_q <= to_bcd(count_d);
    end

    assign bcd_tens = bcd_q[7:4];
    assign bcd_ones = bcd_q[3:0];
`endif

endmodule

// File: tb/tb_prog_countdown_7.sv
// Directed bench for prog_countdown_7: a PRESCALE=1 instance and a PRESCALE=3 instance.
module tb_prog_countdown_7;
    import prog_count_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance A: PRESCALE = 1
    logic         rst_a, load_a, run_a, busy_a, done_a;
    logic [6:0]   start_a, cnt_a;
    state_e       st_a;
`ifdef PROG_COUNTDOWN_BCD_EN
    logic [3:0]   tens_a, ones_a;
`endif

    // Instance B: PRESCALE = 3
    logic         rst_b, load_b, run_b, busy_b, done_b;
    logic [6:0]   start_b, cnt_b;
    state_e       st_b;
`ifdef PROG_COUNTDOWN_BCD_EN
    logic [3:0]   tens_b, ones_b;
`endif

    prog_countdown_7 #(.PRESCALE(1)) dut_a (
        .CLK(clk), .reset(rst_a), .start_count(start_a), .load(load_a), .run(run_a),
        .count_out(cnt_a), .busy(busy_a), .done(done_a),
`ifdef PROG_COUNTDOWN_BCD_EN
        .bcd_tens(tens_a), .bcd_ones(ones_a),
`endif
        .state_dbg_o(st_a)
    );

    prog_countdown_7 #(.PRESCALE(3)) dut_b (
        .CLK(clk), .reset(rst_b), .start_count(start_b), .load(load_b), .run(run_b),
        .count_out(cnt_b), .busy(busy_b), .done(done_b),
`ifdef PROG_COUNTDOWN_BCD_EN
        .bcd_tens(tens_b), .bcd_ones(ones_b),
`endif
        .state_dbg_o(st_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first_done;
        int pulses;

        rst_a = 1'b1; load_a = 1'b0; run_a = 1'b0; start_a = '0;
        rst_b = 1'b1; load_b = 1'b0; run_b = 1'b0; start_b = '0;
        step();
        step();

        // Reset values
        check("rst_cnt_a",  32'(cnt_a), 0);
        check("rst_busy_a", 32'(busy_a), 0);
        check("rst_done_a", 32'(done_a), 0);
        check("rst_st_a",   32'(st_a), 32'(ST_IDLE));
        check("rst_cnt_b",  32'(cnt_b), 0);
`ifdef PROG_COUNTDOWN_BCD_EN
        check("rst_tens_a", 32'(tens_a), 0);
        check("rst_ones_a", 32'(ones_a), 0);
`endif
        rst_a = 1'b0;
        rst_b = 1'b0;

        // IDLE ignores run
        run_a = 1'b1;
        step();
        step();
        check("idle_st_a",  32'(st_a), 32'(ST_IDLE));
        check("idle_cnt_a", 32'(cnt_a), 0);

        // Load 5 with run high: load wins, HOLD first
        load_a = 1'b1; start_a = 7'd5;
        step();
        check("ld5_cnt",  32'(cnt_a), 5);
        check("ld5_st",   32'(st_a), 32'(ST_HOLD));
        check("ld5_busy", 32'(busy_a), 0);
        load_a = 1'b0;
        step();
        check("ent_st",   32'(st_a), 32'(ST_COUNT));
        check("ent_busy", 32'(busy_a), 1);
        check("ent_cnt",  32'(cnt_a), 5);
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("seq_cnt_%0d", i), 32'(cnt_a), 32'(5 - i));
            check($sformatf("seq_done_%0d", i), 32'(done_a), (i == 5) ? 1 : 0);
        end
        check("fin_busy", 32'(busy_a), 0);
        check("fin_st",   32'(st_a), 32'(ST_DONE));
        step();
        check("fin_done_clr", 32'(done_a), 0);
        check("fin_hold0",    32'(cnt_a), 0);
        check("fin_st2",      32'(st_a), 32'(ST_DONE));

        // Clamp: 120 loads as 99
        run_a = 1'b0;
        load_a = 1'b1; start_a = 7'd120;
        step();
        check("clamp_cnt", 32'(cnt_a), 99);
        check("clamp_st",  32'(st_a), 32'(ST_HOLD));

        // Load 0 with run: one edge in HOLD, then done with no decrement
        start_a = 7'd0; run_a = 1'b1;
        step();
        check("z_cnt",  32'(cnt_a), 0);
        check("z_st",   32'(st_a), 32'(ST_HOLD));
        check("z_done", 32'(done_a), 0);
        load_a = 1'b0;
        step();
        check("z_st2",   32'(st_a), 32'(ST_DONE));
        check("z_done2", 32'(done_a), 1);
        check("z_cnt2",  32'(cnt_a), 0);
        step();
        check("z_done3", 32'(done_a), 0);
        check("z_cnt3",  32'(cnt_a), 0);

        // Load collides with the decrement that would reach zero
        load_a = 1'b1; start_a = 7'd2;
        step();
        load_a = 1'b0;
        step();
        step();
        check("col_pre_cnt", 32'(cnt_a), 1);
        check("col_pre_st",  32'(st_a), 32'(ST_COUNT));
        load_a = 1'b1; start_a = 7'd9;
        step();
        check("col_cnt",  32'(cnt_a), 9);
        check("col_st",   32'(st_a), 32'(ST_HOLD));
        check("col_done", 32'(done_a), 0);
        check("col_busy", 32'(busy_a), 0);
        load_a = 1'b0;
        step();
        check("col_st2",  32'(st_a), 32'(ST_COUNT));
        step();
        check("col_cnt2", 32'(cnt_a), 8);

        // Asynchronous reset mid-cycle
        #3;
        rst_a = 1'b1;
        #1;
        check("ar_cnt",  32'(cnt_a), 0);
        check("ar_busy", 32'(busy_a), 0);
        check("ar_done", 32'(done_a), 0);
        check("ar_st",   32'(st_a), 32'(ST_IDLE));
        step();
        rst_a = 1'b0;
        step();
        step();
        check("ar_stay_st",  32'(st_a), 32'(ST_IDLE));
        check("ar_stay_cnt", 32'(cnt_a), 0);

`ifdef PROG_COUNTDOWN_BCD_EN
        // BCD: 47 then eight decrements gives 39
        run_a = 1'b0;
        load_a = 1'b1; start_a = 7'd47;
        step();
        load_a = 1'b0;
        check("bcd_tens47", 32'(tens_a), 4);
        check("bcd_ones47", 32'(ones_a), 7);
        run_a = 1'b1;
        step();
        for (int i = 0; i < 8; i++)
            step();
        run_a = 1'b0;
        check("bcd_cnt39",  32'(cnt_a), 39);
        check("bcd_tens39", 32'(tens_a), 3);
        check("bcd_ones39", 32'(ones_a), 9);
`endif

        // PRESCALE=3: load 4 with run high, pause 5 edges after first decrement
        load_b = 1'b1; start_b = 7'd4; run_b = 1'b1;
        step();
        load_b = 1'b0;
        check("p3_ld_cnt", 32'(cnt_b), 4);
        check("p3_ld_st",  32'(st_b), 32'(ST_HOLD));
        step();
        check("p3_ent_st", 32'(st_b), 32'(ST_COUNT));
        first_done = 0;
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            run_b = !(i >= 4 && i <= 8);
            step();
            if (done_b === 1'b1) begin
                pulses++;
                if (first_done == 0)
                    first_done = i;
            end
            if (i == 2) check("p3_e2_cnt", 32'(cnt_b), 4);
            if (i == 3) check("p3_e3_cnt", 32'(cnt_b), 3);
            if (i == 8) begin
                check("p3_pause_cnt", 32'(cnt_b), 3);
                check("p3_pause_st",  32'(st_b), 32'(ST_HOLD));
                check("p3_pause_busy", 32'(busy_b), 0);
            end
            if (i == 9) check("p3_reent_st", 32'(st_b), 32'(ST_COUNT));
            if (i == 12) check("p3_e12_cnt", 32'(cnt_b), 2);
            if (i == 17) check("p3_e17_cnt", 32'(cnt_b), 1);
            if (i == 18) begin
                check("p3_e18_cnt",  32'(cnt_b), 0);
                check("p3_e18_busy", 32'(busy_b), 0);
                check("p3_e18_st",   32'(st_b), 32'(ST_DONE));
            end
        end
        check("p3_done_edge",   32'(first_done), 18);
        check("p3_done_pulses", 32'(pulses), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
